lab4_i2c_xbar_arb: RTL and testbench

- Two-master, twelve-slave crossbar arbiter for the LAB4 DAC I2C busses.
- Masters: port wb0 is the LAB4 control path; port wb1 is the RFP path. Slaves: twelve OpenCores I2C controllers, one per LAB4.
- Each master can lock one controller for the full duration of its WISHBONE cycle. Both masters may own different controllers concurrently.
- Provides per-controller round-robin conflict resolution, illegal-target and cross-target error returns, and a stuck-slave ack timeout.

---
 rtl/lab4_i2c_xbar_arb.sv | 239 +++++++++++++++++++++++
 tb/tb_lab4_i2c_xbar_arb.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab4_i2c_xbar_arb.sv
// Two-master / NUM_CTRL-slave WISHBONE crossbar for the LAB4 DAC I2C controllers.
// A master locks one controller for its whole cycle; ties are resolved round-robin per controller.
//
// state | meaning
// IDLE  | no request pending
// WAIT  | target captured, waiting for the controller lock
// OWN   | controller locked, accesses pass through
// ERR   | one-cycle err_o termination (illegal index or cross-target access)

module lab4_i2c_xbar_arb #(
  parameter int NUM_CTRL = 12,
  parameter int TIMEOUT  = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wb0_cyc_i,
  input  logic                  wb0_stb_i,
  input  logic                  wb0_we_i,
  input  logic [6:0]            wb0_adr_i,
  input  logic [7:0]            wb0_dat_i,
  output logic [7:0]            wb0_dat_o,
  output logic                  wb0_ack_o,
  output logic                  wb0_err_o,
  output logic                  wb0_rty_o,
  input  logic                  wb1_cyc_i,
  input  logic                  wb1_stb_i,
  input  logic                  wb1_we_i,
  input  logic [6:0]            wb1_adr_i,
  input  logic [7:0]            wb1_dat_i,
  output logic [7:0]            wb1_dat_o,
  output logic                  wb1_ack_o,
  output logic                  wb1_err_o,
  output logic                  wb1_rty_o,
  output logic [NUM_CTRL-1:0]   i2c_cyc_o,
  output logic [NUM_CTRL-1:0]   i2c_stb_o,
  output logic [NUM_CTRL-1:0]   i2c_we_o,
  output logic [3*NUM_CTRL-1:0] i2c_adr_o,
  output logic [8*NUM_CTRL-1:0] i2c_dat_o,
  input  logic [8*NUM_CTRL-1:0] i2c_dat_i,
  input  logic [NUM_CTRL-1:0]   i2c_ack_i,
  output logic [NUM_CTRL-1:0]   lock_o,
  output logic [NUM_CTRL-1:0]   owner_o
);

  typedef enum logic [1:0] {IDLE, WAIT, OWN, ERR} state_t;

  logic [1:0] cyc, stb, we;
  logic [3:0] idx  [2];
  logic [2:0] radr [2];
  logic [7:0] wdat [2];

  assign cyc     = {wb1_cyc_i, wb0_cyc_i};
  assign stb     = {wb1_stb_i, wb0_stb_i};
  assign we      = {wb1_we_i, wb0_we_i};
  assign idx[0]  = wb0_adr_i[6:3];
  assign idx[1]  = wb1_adr_i[6:3];
  assign radr[0] = wb0_adr_i[2:0];
  assign radr[1] = wb1_adr_i[2:0];
  assign wdat[0] = wb0_dat_i;
  assign wdat[1] = wb1_dat_i;

  state_t              state_q [2];
  state_t              state_d [2];
  logic [3:0]          tgt_q [2];
  logic [3:0]          tgt_d [2];
  logic [7:0]          cnt_q [2];
  logic [7:0]          cnt_d [2];
  logic [1:0]          from_own_q, from_own_d;
  logic [1:0]          hold_q, hold_d;
  logic [NUM_CTRL-1:0] last_q, last_d;
  logic [NUM_CTRL-1:0] lock;

  logic [1:0] holding, waiting, free, last_sel, ack_sel, grant;
  logic [1:0] req_match, mism, tmo, fwd_stb, ack, err;
  logic [7:0] rdat_sel [2];
  logic [7:0] rdat [2];
  logic       tie;

  // A master holds its controller in OWN and while an OWN mismatch error is being returned.
  always_comb begin
    holding = '0;
    waiting = '0;
    for (int m = 0; m < 2; m++) begin
      holding[m] = (state_q[m] == OWN) || ((state_q[m] == ERR) && from_own_q[m]);
      waiting[m] = (state_q[m] == WAIT) && cyc[m];
    end
  end

  always_comb begin
    lock = '0;
    for (int k = 0; k < NUM_CTRL; k++)
      for (int m = 0; m < 2; m++)
        if (holding[m] && (tgt_q[m] == 4'(k))) lock[k] = 1'b1;
  end

  always_comb begin
    free        = '0;
    last_sel    = '0;
    ack_sel     = '0;
    rdat_sel[0] = '0;
    rdat_sel[1] = '0;
    for (int k = 0; k < NUM_CTRL; k++)
      for (int m = 0; m < 2; m++)
        if (tgt_q[m] == 4'(k)) begin
          free[m]     = !lock[k];
          last_sel[m] = last_q[k];
          ack_sel[m]  = i2c_ack_i[k];
          rdat_sel[m] = i2c_dat_i[8*k +: 8];
        end
  end

  // last_q[k] = 1 means wb1 won controller k last time, so wb0 wins the next tie.
  always_comb begin
    grant    = '0;
    tie      = waiting[0] && waiting[1] && (tgt_q[0] == tgt_q[1]);
    grant[0] = waiting[0] && free[0] && (!tie || last_sel[0]);
    grant[1] = waiting[1] && free[1] && (!tie || !last_sel[1]);
  end

  always_comb begin
    req_match = '0;
    mism      = '0;
    tmo       = '0;
    fwd_stb   = '0;
    ack       = '0;
    err       = '0;
    rdat[0]   = '0;
    rdat[1]   = '0;
    for (int m = 0; m < 2; m++) begin
      req_match[m] = (state_q[m] == OWN) && cyc[m] && stb[m] && !hold_q[m] &&
                     (idx[m] == tgt_q[m]);
      mism[m]      = (state_q[m] == OWN) && cyc[m] && stb[m] && !hold_q[m] &&
                     (idx[m] != tgt_q[m]);
      tmo[m]       = req_match[m] && (cnt_q[m] == 8'(TIMEOUT));
      fwd_stb[m]   = req_match[m] && !tmo[m];
      ack[m]       = fwd_stb[m] && ack_sel[m];
      err[m]       = (state_q[m] == ERR) || tmo[m];
      rdat[m]      = (state_q[m] == OWN) ? rdat_sel[m] : 8'h00;
    end
  end

  always_comb begin
    last_d = last_q;
    for (int m = 0; m < 2; m++) begin
      state_d[m]    = state_q[m];
      tgt_d[m]      = tgt_q[m];
      from_own_d[m] = from_own_q[m];
      // Once an error has been returned, the same strobe must drop before it is looked at again.
      hold_d[m]     = (cyc[m] && stb[m]) ? (hold_q[m] || (state_q[m] == ERR)) : 1'b0;
      cnt_d[m]      = (fwd_stb[m] && !ack_sel[m]) ? cnt_q[m] + 8'd1 : 8'd0;
      case (state_q[m])
        IDLE: begin
          if (cyc[m] && stb[m] && !hold_q[m]) begin
            if ({1'b0, idx[m]} >= 5'(NUM_CTRL)) begin
              state_d[m]    = ERR;
              from_own_d[m] = 1'b0;
            end else begin
              tgt_d[m]   = idx[m];
              state_d[m] = WAIT;
            end
          end
        end
        WAIT: begin
          if (!cyc[m])        state_d[m] = IDLE;
          else if (grant[m])  state_d[m] = OWN;
        end
        OWN: begin
          if (!cyc[m]) begin
            state_d[m] = IDLE;
          end else if (mism[m]) begin
            state_d[m]    = ERR;
            from_own_d[m] = 1'b1;
          end
        end
        ERR: begin
          state_d[m] = (from_own_q[m] && cyc[m] && stb[m]) ? OWN : IDLE;
        end
        default: state_d[m] = IDLE;
      endcase
    end
    for (int k = 0; k < NUM_CTRL; k++)
      for (int m = 0; m < 2; m++)
        if (grant[m] && (tgt_q[m] == 4'(k))) last_d[k] = (m == 1);
  end

  always_comb begin
    i2c_cyc_o = '0;
    i2c_stb_o = '0;
    i2c_we_o  = '0;
    i2c_adr_o = '0;
    i2c_dat_o = '0;
    owner_o   = '0;
    for (int k = 0; k < NUM_CTRL; k++)
      for (int m = 0; m < 2; m++)
        if (holding[m] && (tgt_q[m] == 4'(k))) begin
          i2c_cyc_o[k] = cyc[m];
          i2c_stb_o[k] = fwd_stb[m];
          owner_o[k]   = (m == 1);
          if (idx[m] == tgt_q[m]) begin
            i2c_we_o[k]          = we[m];
            i2c_adr_o[3*k +: 3]  = radr[m];
            i2c_dat_o[8*k +: 8]  = wdat[m];
          end
        end
  end

  assign lock_o    = lock;
  assign wb0_ack_o = ack[0];
  assign wb0_err_o = err[0];
  assign wb0_dat_o = rdat[0];
  assign wb0_rty_o = 1'b0;
  assign wb1_ack_o = ack[1];
  assign wb1_err_o = err[1];
  assign wb1_dat_o = rdat[1];
  assign wb1_rty_o = 1'b0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int m = 0; m < 2; m++) begin
        state_q[m] <= IDLE;
        tgt_q[m]   <= '0;
        cnt_q[m]   <= '0;
      end
      from_own_q <= '0;
      hold_q     <= '0;
      last_q     <= '1;
    end else begin
      for (int m = 0; m < 2; m++) begin
        state_q[m] <= state_d[m];
        tgt_q[m]   <= tgt_d[m];
        cnt_q[m]   <= cnt_d[m];
      end
      from_own_q <= from_own_d;
      hold_q     <= hold_d;
      last_q     <= last_d;
    end
  end

endmodule

// File: tb/tb_lab4_i2c_xbar_arb.sv
// Self-checking bench for lab4_i2c_xbar_arb: directed scenarios plus randomized single-master
// accesses checked against a transaction-level model (2-cycle grant, per-controller round-robin).

module tb_lab4_i2c_xbar_arb;
  localparam int NC  = 12;
  localparam int TMO = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic wb0_cyc_i, wb0_stb_i, wb0_we_i, wb1_cyc_i, wb1_stb_i, wb1_we_i;
  logic [6:0] wb0_adr_i, wb1_adr_i;
  logic [7:0] wb0_dat_i, wb1_dat_i, wb0_dat_o, wb1_dat_o;
  logic wb0_ack_o, wb0_err_o, wb0_rty_o, wb1_ack_o, wb1_err_o, wb1_rty_o;
  logic [NC-1:0] i2c_cyc_o, i2c_stb_o, i2c_we_o, i2c_ack_i, lock_o, owner_o;
  logic [3*NC-1:0] i2c_adr_o;
  logic [8*NC-1:0] i2c_dat_o, i2c_dat_i;

  int checks = 0;
  int errors = 0;
  int last_win [NC];

  always #5 clk_i = ~clk_i;

  lab4_i2c_xbar_arb #(.NUM_CTRL(NC), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb0_cyc_i(wb0_cyc_i), .wb0_stb_i(wb0_stb_i), .wb0_we_i(wb0_we_i), .wb0_adr_i(wb0_adr_i),
    .wb0_dat_i(wb0_dat_i), .wb0_dat_o(wb0_dat_o), .wb0_ack_o(wb0_ack_o), .wb0_err_o(wb0_err_o),
    .wb0_rty_o(wb0_rty_o),
    .wb1_cyc_i(wb1_cyc_i), .wb1_stb_i(wb1_stb_i), .wb1_we_i(wb1_we_i), .wb1_adr_i(wb1_adr_i),
    .wb1_dat_i(wb1_dat_i), .wb1_dat_o(wb1_dat_o), .wb1_ack_o(wb1_ack_o), .wb1_err_o(wb1_err_o),
    .wb1_rty_o(wb1_rty_o),
    .i2c_cyc_o(i2c_cyc_o), .i2c_stb_o(i2c_stb_o), .i2c_we_o(i2c_we_o), .i2c_adr_o(i2c_adr_o),
    .i2c_dat_o(i2c_dat_o), .i2c_dat_i(i2c_dat_i), .i2c_ack_i(i2c_ack_i),
    .lock_o(lock_o), .owner_o(owner_o)
  );

  task automatic drive(input int m, input logic c, input logic s, input logic w,
                       input logic [6:0] a, input logic [7:0] d);
    if (m == 0) begin
      wb0_cyc_i = c; wb0_stb_i = s; wb0_we_i = w; wb0_adr_i = a; wb0_dat_i = d;
    end else begin
      wb1_cyc_i = c; wb1_stb_i = s; wb1_we_i = w; wb1_adr_i = a; wb1_dat_i = d;
    end
  endtask

  task automatic reset_model;
    for (int k = 0; k < NC; k++) last_win[k] = 1;
  endtask

  task automatic test_reset;
    drive(0, 0, 0, 0, 7'h00, 8'h00);
    drive(1, 0, 0, 0, 7'h00, 8'h00);
    i2c_ack_i = '0;
    i2c_dat_i = '0;
    reset_model();
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({lock_o, owner_o, i2c_cyc_o, i2c_stb_o, i2c_we_o} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl lock=%h owner=%h cyc=%h stb=%h we=%h want all 0",
               lock_o, owner_o, i2c_cyc_o, i2c_stb_o, i2c_we_o);
    end
    checks++;
    if ({i2c_adr_o, i2c_dat_o} !== '0) begin
      errors++;
      $display("FAIL reset_bus adr=%h dat=%h want 0", i2c_adr_o, i2c_dat_o);
    end
    checks++;
    if ({wb0_dat_o, wb0_ack_o, wb0_err_o, wb0_rty_o, wb1_dat_o, wb1_ack_o, wb1_err_o, wb1_rty_o} !== '0) begin
      errors++;
      $display("FAIL reset_wb got %h %b%b%b %h %b%b%b want 0", wb0_dat_o, wb0_ack_o, wb0_err_o,
               wb0_rty_o, wb1_dat_o, wb1_ack_o, wb1_err_o, wb1_rty_o);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_basic_read;
    logic [NC-1:0] exp;
    exp = '0;
    exp[3] = 1'b1;
    i2c_dat_i = '0;
    i2c_dat_i[31:24] = 8'h5C;
    drive(0, 1, 1, 0, 7'h1A, 8'h00);
    @(negedge clk_i);
    checks++;
    if (i2c_stb_o !== '0) begin
      errors++; $display("FAIL basic_capture stb=%h want 0", i2c_stb_o);
    end
    @(negedge clk_i);
    checks++;
    if (i2c_stb_o !== exp || i2c_cyc_o !== exp) begin
      errors++; $display("FAIL basic_fwd stb=%h cyc=%h want %h", i2c_stb_o, i2c_cyc_o, exp);
    end
    checks++;
    if (lock_o !== exp || owner_o !== '0) begin
      errors++; $display("FAIL basic_lock lock=%h owner=%h want %h 0", lock_o, owner_o, exp);
    end
    checks++;
    if (i2c_adr_o[11:9] !== 3'd2 || i2c_we_o !== '0 || wb0_ack_o !== 1'b0) begin
      errors++; $display("FAIL basic_adr adr=%h we=%h ack=%b want 2 0 0", i2c_adr_o[11:9], i2c_we_o, wb0_ack_o);
    end
    last_win[3] = 0;
    i2c_ack_i[3] = 1'b1;
    #1;
    checks++;
    if ({wb0_ack_o, wb0_err_o, wb0_dat_o} !== {1'b1, 1'b0, 8'h5C}) begin
      errors++; $display("FAIL basic_ack ack=%b err=%b dat=%h want 1 0 5c", wb0_ack_o, wb0_err_o, wb0_dat_o);
    end
    @(negedge clk_i);
    i2c_ack_i = '0;
    drive(0, 0, 0, 0, 7'h00, 8'h00);
    #1;
    checks++;
    if (i2c_cyc_o !== '0) begin
      errors++; $display("FAIL basic_release_cyc cyc=%h want 0", i2c_cyc_o);
    end
    @(negedge clk_i);
    checks++;
    if (lock_o !== '0 || wb0_dat_o !== 8'h00) begin
      errors++; $display("FAIL basic_release_lock lock=%h dat=%h want 0", lock_o, wb0_dat_o);
    end
  endtask

  task automatic tie_round;
    int w, l;
    logic [NC-1:0] b7;
    logic [6:0] aw, al;
    b7 = '0;
    b7[7] = 1'b1;
    w = (last_win[7] == 1) ? 0 : 1;
    l = 1 - w;
    aw = (w == 0) ? 7'h3A : 7'h3D;
    al = (l == 0) ? 7'h3A : 7'h3D;
    drive(0, 1, 1, 0, 7'h3A, 8'h00);
    drive(1, 1, 1, 0, 7'h3D, 8'h00);
    @(negedge clk_i);
    checks++;
    if (lock_o !== '0) begin
      errors++; $display("FAIL tie_capture lock=%h want 0", lock_o);
    end
    @(negedge clk_i);
    checks++;
    if (lock_o !== b7 || owner_o !== ((w == 1) ? b7 : '0) || i2c_stb_o !== b7) begin
      errors++;
      $display("FAIL tie_grant lock=%h owner=%h stb=%h want winner wb%0d", lock_o, owner_o, i2c_stb_o, w);
    end
    last_win[7] = w;
    drive(w, 1, 0, 0, aw, 8'h00);
    repeat (2) @(negedge clk_i);
    checks++;
    if (lock_o !== b7 || owner_o !== ((w == 1) ? b7 : '0)) begin
      errors++; $display("FAIL tie_nopreempt lock=%h owner=%h want winner wb%0d", lock_o, owner_o, w);
    end
    drive(w, 0, 0, 0, aw, 8'h00);
    #1;
    checks++;
    if (i2c_cyc_o !== '0) begin
      errors++; $display("FAIL tie_drop_cyc cyc=%h want 0", i2c_cyc_o);
    end
    @(negedge clk_i);
    checks++;
    if (lock_o !== '0) begin
      errors++; $display("FAIL tie_freed lock=%h want 0", lock_o);
    end
    @(negedge clk_i);
    checks++;
    if (lock_o !== b7 || owner_o !== ((l == 1) ? b7 : '0)) begin
      errors++; $display("FAIL tie_handover lock=%h owner=%h want wb%0d", lock_o, owner_o, l);
    end
    last_win[7] = l;
    drive(l, 0, 0, 0, al, 8'h00);
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_arbitration;
    tie_round();
    tie_round();
  endtask

  task automatic test_concurrent;
    logic [7:0] d0, d1;
    logic [2:0] r0, r1;
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    r0 = 3'($urandom);
    r1 = 3'($urandom);
    drive(0, 1, 1, 1, {4'd2, r0}, d0);
    drive(1, 1, 1, 1, {4'd9, r1}, d1);
    repeat (2) @(negedge clk_i);
    checks++;
    if (lock_o !== 12'h204 || owner_o !== 12'h200) begin
      errors++; $display("FAIL conc_lock lock=%h owner=%h want 204 200", lock_o, owner_o);
    end
    checks++;
    if (i2c_stb_o !== 12'h204 || i2c_we_o !== 12'h204) begin
      errors++; $display("FAIL conc_stb stb=%h we=%h want 204", i2c_stb_o, i2c_we_o);
    end
    checks++;
    if ({i2c_dat_o[23:16], i2c_dat_o[79:72], i2c_adr_o[8:6], i2c_adr_o[29:27]} !== {d0, d1, r0, r1}) begin
      errors++;
      $display("FAIL conc_data dat2=%h dat9=%h adr2=%h adr9=%h want %h %h %h %h", i2c_dat_o[23:16],
               i2c_dat_o[79:72], i2c_adr_o[8:6], i2c_adr_o[29:27], d0, d1, r0, r1);
    end
    last_win[2] = 0;
    last_win[9] = 1;
    i2c_ack_i[2] = 1'b1;
    i2c_ack_i[9] = 1'b1;
    #1;
    checks++;
    if ({wb0_ack_o, wb1_ack_o, wb0_err_o, wb1_err_o} !== 4'b1100) begin
      errors++; $display("FAIL conc_ack ack=%b%b err=%b%b want 11 00", wb0_ack_o, wb1_ack_o, wb0_err_o, wb1_err_o);
    end
    @(negedge clk_i);
    i2c_ack_i = '0;
    drive(0, 0, 0, 0, 7'h00, 8'h00);
    drive(1, 0, 0, 0, 7'h00, 8'h00);
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_errors;
    drive(1, 1, 1, 0, 7'h60, 8'h00);
    #1;
    checks++;
    if (wb1_err_o !== 1'b0) begin
      errors++; $display("FAIL illegal_early err=%b want 0", wb1_err_o);
    end
    @(negedge clk_i);
    checks++;
    if (wb1_err_o !== 1'b1 || wb1_ack_o !== 1'b0 || i2c_cyc_o !== '0) begin
      errors++; $display("FAIL illegal_err err=%b ack=%b cyc=%h want 1 0 0", wb1_err_o, wb1_ack_o, i2c_cyc_o);
    end
    drive(1, 0, 0, 0, 7'h00, 8'h00);
    @(negedge clk_i);
    checks++;
    if (wb1_err_o !== 1'b0 || i2c_cyc_o !== '0) begin
      errors++; $display("FAIL illegal_pulse err=%b cyc=%h want 0 0", wb1_err_o, i2c_cyc_o);
    end
    drive(0, 1, 1, 1, {4'd4, 3'd1}, 8'hA5);
    repeat (2) @(negedge clk_i);
    last_win[4] = 0;
    checks++;
    if (lock_o !== 12'h010) begin
      errors++; $display("FAIL mism_own lock=%h want 010", lock_o);
    end
    drive(0, 1, 1, 1, {4'd5, 3'd1}, 8'hA5);
    #1;
    checks++;
    if (i2c_stb_o !== '0 || wb0_err_o !== 1'b0) begin
      errors++; $display("FAIL mism_nofwd stb=%h err=%b want 0 0", i2c_stb_o, wb0_err_o);
    end
    @(negedge clk_i);
    checks++;
    if (wb0_err_o !== 1'b1 || wb0_ack_o !== 1'b0 || lock_o !== 12'h010) begin
      errors++; $display("FAIL mism_err err=%b ack=%b lock=%h want 1 0 010", wb0_err_o, wb0_ack_o, lock_o);
    end
    @(negedge clk_i);
    checks++;
    if (wb0_err_o !== 1'b0 || lock_o !== 12'h010 || i2c_stb_o !== '0) begin
      errors++; $display("FAIL mism_after err=%b lock=%h stb=%h want 0 010 0", wb0_err_o, lock_o, i2c_stb_o);
    end
    drive(0, 1, 0, 1, {4'd5, 3'd1}, 8'hA5);
    @(negedge clk_i);
    checks++;
    if (lock_o !== 12'h010 || owner_o !== '0) begin
      errors++; $display("FAIL mism_retain lock=%h owner=%h want 010 0", lock_o, owner_o);
    end
    drive(0, 0, 0, 0, 7'h00, 8'h00);
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_random_access;
    int m, c, dly;
    logic w;
    logic [2:0] r;
    logic [7:0] wd, rd;
    logic [NC-1:0] exp;
    logic got_ack;
    logic [7:0] got_dat;
    for (int it = 0; it < 20; it++) begin
      m   = int'($urandom_range(0, 1));
      c   = int'($urandom_range(0, NC - 1));
      dly = int'($urandom_range(0, TMO - 2));
      w   = 1'($urandom);
      r   = 3'($urandom);
      wd  = 8'($urandom);
      rd  = 8'($urandom);
      exp = '0;
      exp[c] = 1'b1;
      i2c_dat_i = '0;
      i2c_dat_i[8*c +: 8] = rd;
      drive(m, 1, 1, w, {4'(c), r}, wd);
      @(negedge clk_i);
      checks++;
      if (i2c_stb_o !== '0) begin
        errors++; $display("FAIL rnd_capture it=%0d stb=%h want 0", it, i2c_stb_o);
      end
      @(negedge clk_i);
      last_win[c] = m;
      checks++;
      if (i2c_stb_o !== exp || lock_o !== exp || owner_o !== ((m == 1) ? exp : '0)) begin
        errors++;
        $display("FAIL rnd_grant it=%0d stb=%h lock=%h owner=%h want %h m=%0d", it, i2c_stb_o, lock_o, owner_o, exp, m);
      end
      checks++;
      if (i2c_adr_o[3*c +: 3] !== r || i2c_we_o !== (w ? exp : '0) || (w && i2c_dat_o[8*c +: 8] !== wd)) begin
        errors++;
        $display("FAIL rnd_fields it=%0d adr=%h we=%h dat=%h want %h %b %h", it, i2c_adr_o[3*c +: 3], i2c_we_o,
                 i2c_dat_o[8*c +: 8], r, w, wd);
      end
      for (int d = 0; d < dly; d++) begin
        got_ack = (m == 1) ? wb1_ack_o : wb0_ack_o;
        checks++;
        if (got_ack !== 1'b0 || i2c_stb_o !== exp) begin
          errors++; $display("FAIL rnd_wait it=%0d ack=%b stb=%h want 0 %h", it, got_ack, i2c_stb_o, exp);
        end
        @(negedge clk_i);
      end
      i2c_ack_i[c] = 1'b1;
      #1;
      got_ack = (m == 1) ? wb1_ack_o : wb0_ack_o;
      got_dat = (m == 1) ? wb1_dat_o : wb0_dat_o;
      checks++;
      if (got_ack !== 1'b1 || got_dat !== rd) begin
        errors++; $display("FAIL rnd_ack it=%0d ack=%b dat=%h want 1 %h", it, got_ack, got_dat, rd);
      end
      @(negedge clk_i);
      i2c_ack_i = '0;
      drive(m, 0, 0, 0, 7'h00, 8'h00);
      #1;
      checks++;
      if (i2c_cyc_o !== '0) begin
        errors++; $display("FAIL rnd_release it=%0d cyc=%h want 0", it, i2c_cyc_o);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_timeout_reset;
    drive(0, 1, 1, 0, 7'h03, 8'h00);
    repeat (2) @(negedge clk_i);
    last_win[0] = 0;
    for (int n = 1; n <= TMO; n++) begin
      checks++;
      if (i2c_stb_o !== 12'h001 || wb0_err_o !== 1'b0) begin
        errors++; $display("FAIL tmo_fwd cycle=%0d stb=%h err=%b want 001 0", n, i2c_stb_o, wb0_err_o);
      end
      @(negedge clk_i);
    end
    checks++;
    if (wb0_err_o !== 1'b1 || i2c_stb_o !== '0 || lock_o !== 12'h001) begin
      errors++; $display("FAIL tmo_err err=%b stb=%h lock=%h want 1 0 001", wb0_err_o, i2c_stb_o, lock_o);
    end
    i2c_ack_i[0] = 1'b1;
    #1;
    checks++;
    if (wb0_ack_o !== 1'b0 || wb0_err_o !== 1'b1) begin
      errors++; $display("FAIL tmo_late_ack ack=%b err=%b want 0 1", wb0_ack_o, wb0_err_o);
    end
    i2c_ack_i = '0;
    @(negedge clk_i);
    checks++;
    if (wb0_err_o !== 1'b0 || i2c_stb_o !== 12'h001) begin
      errors++; $display("FAIL tmo_restart err=%b stb=%h want 0 001", wb0_err_o, i2c_stb_o);
    end
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if ({lock_o, owner_o, i2c_cyc_o, i2c_stb_o, wb0_err_o, wb0_ack_o, wb0_dat_o} !== '0) begin
      errors++;
      $display("FAIL async_reset lock=%h cyc=%h stb=%h err=%b ack=%b dat=%h want 0", lock_o, i2c_cyc_o,
               i2c_stb_o, wb0_err_o, wb0_ack_o, wb0_dat_o);
    end
    drive(0, 0, 0, 0, 7'h00, 8'h00);
    reset_model();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_read();
    test_arbitration();
    test_concurrent();
    test_errors();
    test_random_access();
    test_timeout_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
